// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the GRF read-side hazard logic: bypass select codes,
// the "source unused" Tuse marker and the Tnew classes of producers.
package hazard_unit_pkg;

  // D-stage operand select
  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;

  // E-stage operand select
  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  // M-stage store data select
  localparam logic       FWD_M_PIPE = 1'b0;
  localparam logic       FWD_M_W    = 1'b1;

  localparam logic [1:0] TUSE_NONE  = 2'd3;

  localparam logic [1:0] TNEW_IMM   = 2'd0;
  localparam logic [1:0] TNEW_ALU   = 2'd1;
  localparam logic [1:0] TNEW_LOAD  = 2'd2;

endpackage

// File: rtl/hazard_unit_src_check.sv
// Hazard check for one D-stage source register against the producers in E and M.
// The E producer is younger, so it is searched first and shadows an M match.
module hazard_src_check
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic [REG_AW-1:0] src,
  input  logic [TW-1:0]     tuse,
  input  logic [REG_AW-1:0] e_wa,
  input  logic [TW-1:0]     e_tnew,
  input  logic [REG_AW-1:0] m_wa,
  input  logic [TW-1:0]     m_tnew,
  output logic              stall_src,
  output logic [1:0]        fwd_sel
);

  logic src_live_s;

  assign src_live_s = (src != {REG_AW{1'b0}}) && (tuse != TW'(TUSE_NONE));

  // Stall when the nearest producer is not ready in time; bypass when its value already exists.
  always_comb begin
    stall_src = 1'b0;
    fwd_sel   = FWD_D_GRF;
    if (!src_live_s) begin
      stall_src = 1'b0;
    end else if (e_wa == src) begin
      if (e_tnew > tuse) begin
        stall_src = 1'b1;
      end else if (e_tnew == {TW{1'b0}}) begin
        fwd_sel = FWD_D_E;
      end else begin
        fwd_sel = FWD_D_GRF;
      end
    end else if (m_wa == src) begin
      if (m_tnew > tuse) begin
        stall_src = 1'b1;
      end else if (m_tnew == {TW{1'b0}}) begin
        fwd_sel = FWD_D_M;
      end else begin
        fwd_sel = FWD_D_GRF;
      end
    end else begin
      fwd_sel = FWD_D_GRF;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// GRF read-side hazard unit: shadows the destination and Tnew of every in-flight
// instruction, decides stall/bypass for D, E and M, and counts stall cycles.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_is_md,
  input  logic              md_busy,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic              fwd_m_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] e_rs_r, e_rt_r, e_wa_r;
  logic [TW-1:0]     e_tnew_r;
  logic [REG_AW-1:0] m_rt_r, m_wa_r;
  logic [TW-1:0]     m_tnew_r;
  logic [REG_AW-1:0] w_wa_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              stall_rs_s, stall_rt_s, stall_s, bubble_s;
  logic [1:0]        fwd_e_rs_s, fwd_e_rt_s;
  logic              fwd_m_rt_s;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    if (t == {TW{1'b0}}) begin
      return {TW{1'b0}};
    end else begin
      return t - {{(TW-1){1'b0}}, 1'b1};
    end
  endfunction

  // M bypass is only legal once the M producer's value exists (tnew 0); W always holds final data.
  function automatic logic [1:0] e_select(input logic [REG_AW-1:0] src,
                                          input logic [REG_AW-1:0] m_wa,
                                          input logic [TW-1:0]     m_tnew,
                                          input logic [REG_AW-1:0] w_wa);
    if (src == {REG_AW{1'b0}}) begin
      return FWD_E_PIPE;
    end else if ((m_wa == src) && (m_tnew == {TW{1'b0}})) begin
      return FWD_E_M;
    end else if (w_wa == src) begin
      return FWD_E_W;
    end else begin
      return FWD_E_PIPE;
    end
  endfunction

  hazard_src_check #(.REG_AW(REG_AW), .TW(TW)) u_chk_rs (
    .src       (d_rs),
    .tuse      (d_tuse_rs),
    .e_wa      (e_wa_r),
    .e_tnew    (e_tnew_r),
    .m_wa      (m_wa_r),
    .m_tnew    (m_tnew_r),
    .stall_src (stall_rs_s),
    .fwd_sel   (fwd_d_rs)
  );

  hazard_src_check #(.REG_AW(REG_AW), .TW(TW)) u_chk_rt (
    .src       (d_rt),
    .tuse      (d_tuse_rt),
    .e_wa      (e_wa_r),
    .e_tnew    (e_tnew_r),
    .m_wa      (m_wa_r),
    .m_tnew    (m_tnew_r),
    .stall_src (stall_rt_s),
    .fwd_sel   (fwd_d_rt)
  );

  // Stall decision and the later-stage bypass selects.
  always_comb begin
    stall_s    = d_valid & (stall_rs_s | stall_rt_s | (d_is_md & md_busy));
    bubble_s   = stall_s | ~d_valid;
    fwd_e_rs_s = e_select(e_rs_r, m_wa_r, m_tnew_r, w_wa_r);
    fwd_e_rt_s = e_select(e_rt_r, m_wa_r, m_tnew_r, w_wa_r);
    if ((m_rt_r != {REG_AW{1'b0}}) && (w_wa_r == m_rt_r)) begin
      fwd_m_rt_s = FWD_M_W;
    end else begin
      fwd_m_rt_s = FWD_M_PIPE;
    end
  end

  assign stall     = stall_s;
  assign fwd_e_rs  = fwd_e_rs_s;
  assign fwd_e_rt  = fwd_e_rt_s;
  assign fwd_m_rt  = fwd_m_rt_s;
  assign stall_cnt = stall_cnt_r;

  // Shadow pipeline advance and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_r      <= {REG_AW{1'b0}};
      e_rt_r      <= {REG_AW{1'b0}};
      e_wa_r      <= {REG_AW{1'b0}};
      e_tnew_r    <= {TW{1'b0}};
      m_rt_r      <= {REG_AW{1'b0}};
      m_wa_r      <= {REG_AW{1'b0}};
      m_tnew_r    <= {TW{1'b0}};
      w_wa_r      <= {REG_AW{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      w_wa_r      <= m_wa_r;
      m_wa_r      <= e_wa_r;
      m_rt_r      <= e_rt_r;
      m_tnew_r    <= sat_dec(e_tnew_r);
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, stall_s};
      if (bubble_s) begin
        e_rs_r   <= {REG_AW{1'b0}};
        e_rt_r   <= {REG_AW{1'b0}};
        e_wa_r   <= {REG_AW{1'b0}};
        e_tnew_r <= {TW{1'b0}};
      end else begin
        e_rs_r   <= d_rs;
        e_rt_r   <= d_rt;
        e_wa_r   <= d_wa;
        e_tnew_r <= d_tnew;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a history-of-issued-instructions model is
// compared every cycle, and hand-computed values pin each scenario.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic        clk, reset, d_valid, d_is_md, md_busy;
  logic [4:0]  d_rs, d_rt, d_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        stall, fwd_m_rt;
  logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  hazard_unit #(.REG_AW(5), .TW(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_is_md(d_is_md), .md_busy(md_busy), .stall(stall), .fwd_d_rs(fwd_d_rs),
    .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
    .fwd_m_rt(fwd_m_rt), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: hist[k] is the instruction that entered E k cycles ago (k=0 E, 1 M, 2 W).
  typedef struct { logic [4:0] rs, rt, wa; int tnew; } inst_t;
  inst_t       hist [3];
  logic [31:0] m_cnt;

  function automatic int remaining(input int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  function automatic void src_model(input logic [4:0] src, input logic [1:0] tuse,
                                    output bit st, output logic [1:0] sel);
    st = 1'b0; sel = 2'd0;
    if (src != 5'd0 && tuse != TUSE_NONE) begin
      for (int k = 0; k < 2; k++) begin
        if (hist[k].wa == src) begin
          if (remaining(k) > int'(tuse)) st = 1'b1;
          else if (remaining(k) == 0) sel = 2'(k + 1);
          break;
        end
      end
    end
  endfunction

  function automatic logic [1:0] e_model(input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (hist[1].wa == src && remaining(1) == 0) return 2'd1;
    if (hist[2].wa == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic void model_eval(output bit st, output logic [1:0] fdrs, output logic [1:0] fdrt);
    bit s_rs, s_rt;
    src_model(d_rs, d_tuse_rs, s_rs, fdrs);
    src_model(d_rt, d_tuse_rt, s_rt, fdrt);
    st = d_valid & (s_rs | s_rt | (d_is_md & md_busy));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model on each edge using the inputs the DUT saw.
  always @(posedge clk) begin
    bit st; logic [1:0] a, b;
    model_eval(st, a, b);
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '{5'd0, 5'd0, 5'd0, 0};
      m_cnt = 32'd0;
    end else begin
      m_cnt   = m_cnt + 32'(st);
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (st || !d_valid) hist[0] = '{5'd0, 5'd0, 5'd0, 0};
      else                hist[0] = '{d_rs, d_rt, d_wa, int'(d_tnew)};
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit st; logic [1:0] a, b;
    if (chk_en) begin
      model_eval(st, a, b);
      chk("cmp_stall", 32'(stall), 32'(st));
      chk("cmp_fwd_d_rs", 32'(fwd_d_rs), 32'(a));
      chk("cmp_fwd_d_rt", 32'(fwd_d_rt), 32'(b));
      chk("cmp_fwd_e_rs", 32'(fwd_e_rs), 32'(e_model(hist[0].rs)));
      chk("cmp_fwd_e_rt", 32'(fwd_e_rt), 32'(e_model(hist[0].rt)));
      chk("cmp_fwd_m_rt", 32'(fwd_m_rt),
          32'(hist[1].rt != 5'd0 && hist[2].wa == hist[1].rt));
      chk("cmp_stall_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] wa, input logic [1:0] tn,
                       input logic md);
    d_valid = 1'b1; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_wa = wa; d_tnew = tn; d_is_md = md;
  endtask

  task automatic nop();
    d_valid = 1'b0; d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
    d_wa = 5'd0; d_tnew = 2'd0; d_is_md = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; md_busy = 1'b0; nop();
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; md_busy = 1'b0; nop();
    do_reset();
    chk_en = 1'b1;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_sel", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, 1'b0, fwd_m_rt}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);

    // 1: lw $8 then addu $9,$8,$8
    drive(5'd29, 5'd0, 2'd1, TUSE_NONE, 5'd8, TNEW_LOAD, 1'b0); #1;
    chk("t1_no_stall_yet", 32'(stall), 32'd0);
    step(); drive(5'd8, 5'd8, 2'd1, 2'd1, 5'd9, TNEW_ALU, 1'b0); #1;
    chk("t1_stall", 32'(stall), 32'd1);
    step(); #1;
    chk("t1_released", 32'(stall), 32'd0);
    chk("t1_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
    step(); nop(); #1;
    chk("t1_fwd_e_rs", 32'(fwd_e_rs), 32'd2);
    chk("t1_fwd_e_rt", 32'(fwd_e_rt), 32'd2);
    chk("t1_cnt", stall_cnt, 32'd1);

    // 2: addu $8 then beq $8,$0
    do_reset();
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd8, TNEW_ALU, 1'b0);
    step(); drive(5'd8, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_IMM, 1'b0); #1;
    chk("t2_stall", 32'(stall), 32'd1);
    step(); #1;
    chk("t2_released", 32'(stall), 32'd0);
    chk("t2_fwd_d_rs", 32'(fwd_d_rs), 32'd2);

    // 3: lui $5 then addu $6,$5,$5
    do_reset();
    drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd5, TNEW_IMM, 1'b0);
    step(); drive(5'd5, 5'd5, 2'd1, 2'd1, 5'd6, TNEW_ALU, 1'b0); #1;
    chk("t3_stall", 32'(stall), 32'd0);
    chk("t3_fwd_d_rs", 32'(fwd_d_rs), 32'd1);
    chk("t3_fwd_d_rt", 32'(fwd_d_rt), 32'd1);
    step(); nop(); #1;
    chk("t3_fwd_e_rs", 32'(fwd_e_rs), 32'd1);
    chk("t3_fwd_e_rt", 32'(fwd_e_rt), 32'd1);

    // 4: writes to $0 never create a dependency
    do_reset();
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, TNEW_ALU, 1'b0);
    step(); drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd3, TNEW_ALU, 1'b0); #1;
    chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_fwd_d", {fwd_d_rs, fwd_d_rt}, 32'd0);
    step(); nop(); #1;
    chk("t4_fwd_e", {fwd_e_rs, fwd_e_rt}, 32'd0);

    // 5: addu $7 in M, lw $7 in E, beq $7 in D
    do_reset();
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd7, TNEW_ALU, 1'b0);
    step(); drive(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd7, TNEW_LOAD, 1'b0);
    step(); drive(5'd7, 5'd0, 2'd0, 2'd0, 5'd0, TNEW_IMM, 1'b0); #1;
    chk("t5_e_wins", 32'(stall), 32'd1);
    step(); #1;
    chk("t5_m_tnew1", 32'(stall), 32'd1);
    step(); #1;
    chk("t5_released", 32'(stall), 32'd0);
    chk("t5_fwd_d_rs", 32'(fwd_d_rs), 32'd0);
    chk("t5_cnt", stall_cnt, 32'd2);

    // 7: lw $8 then sw $8 -> store data bypassed from W
    do_reset();
    drive(5'd0, 5'd0, 2'd1, TUSE_NONE, 5'd8, TNEW_LOAD, 1'b0);
    step(); drive(5'd0, 5'd8, 2'd1, 2'd2, 5'd0, TNEW_IMM, 1'b0); #1;
    chk("t7_stall", 32'(stall), 32'd0);
    step(); nop(); #1;
    chk("t7_fwd_e_rt", 32'(fwd_e_rt), 32'd0);
    step(); #1;
    chk("t7_fwd_m_rt", 32'(fwd_m_rt), 32'd1);

    // 6: mult then mflo with md_busy, reset mid-stall
    do_reset();
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, TNEW_ALU, 1'b1);
    step(); drive(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd4, TNEW_ALU, 1'b1); md_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; chk("t6_md_stall", 32'(stall), 32'd1);
      step();
    end
    md_busy = 1'b0; #1;
    chk("t6_md_done", 32'(stall), 32'd0);
    chk("t6_cnt", stall_cnt, 32'd5);
    md_busy = 1'b1;
    step(); #1;
    chk("t6_restall", 32'(stall), 32'd1);
    reset = 1'b1;
    step(); md_busy = 1'b0; nop(); #1;
    chk("t6_rst_stall", 32'(stall), 32'd0);
    chk("t6_rst_cnt", stall_cnt, 32'd0);
    reset = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
